// File: rtl/stream_avg_pkg.sv
// Shared types and helpers for the stream averaging decoder.
package stream_avg_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_e;

  localparam int DIN_W  = 4;
  localparam int FRAC_W = 16;

  // Fraction is the low LOG2_WIN sum bits left-aligned into FRAC_W bits.
  function automatic logic [FRAC_W-1:0] avg_frac(input logic [19:0] s, input int unsigned w);
    logic [31:0] t;
    t = ({12'd0, s} & ((32'd1 << w) - 32'd1)) << (FRAC_W - w);
    return t[FRAC_W-1:0];
  endfunction
endpackage

// File: rtl/stream_avg_ctrl.sv
// Measurement sequencer: settle counter, window counter, handshake state.
module stream_avg_ctrl
  import stream_avg_pkg::*;
#(
  parameter int LOG2_WIN = 7,
  parameter int SKIP     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic res_ready,
  output logic acc_clr,
  output logic acc_en,
  output logic done_load,
  output logic busy,
  output logic res_valid
);
  localparam logic [7:0] SKIP_LAST = 8'(SKIP - 1);

  state_e              state_q;
  logic [7:0]          skip_q;
  logic [LOG2_WIN-1:0] win_q;
  logic                busy_q, valid_q;

  assign acc_clr   = (state_q == IDLE) && start;
  assign acc_en    = (state_q == ACCUM);
  assign done_load = acc_en && (&win_q);
  assign busy      = busy_q;
  assign res_valid = valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      skip_q  <= '0;
      win_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          skip_q  <= '0;
          win_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= (SKIP == 0) ? ACCUM : SETTLE;
        end
        SETTLE: begin
          skip_q <= skip_q + 8'd1;
          if (skip_q == SKIP_LAST) state_q <= ACCUM;
        end
        ACCUM: begin
          // Window counter wraps to zero exactly on the last sample.
          win_q <= win_q + 1'b1;
          if (&win_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        DONE: if (res_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/stream_avg_decoder.sv
// Recovers the mean of a 4-bit dither stream over a 2^LOG2_WIN window.
// Optional STREAM_AVG_MINMAX_EN adds din_min/din_max of the accumulated samples.
module stream_avg_decoder
  import stream_avg_pkg::*;
#(
  parameter int LOG2_WIN = 7,
  parameter int SKIP     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIN_W-1:0]          din,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [3:0]                avg_i,
  output logic [FRAC_W-1:0]         avg_f,
  output logic [LOG2_WIN+DIN_W-1:0] sum
`ifdef STREAM_AVG_MINMAX_EN
  ,
  output logic [DIN_W-1:0]          din_min,
  output logic [DIN_W-1:0]          din_max
`endif
);
  localparam int SW = LOG2_WIN + DIN_W;

  logic acc_clr, acc_en, done_load;

  stream_avg_ctrl #(.LOG2_WIN(LOG2_WIN), .SKIP(SKIP)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .res_ready (res_ready),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .done_load (done_load),
    .busy      (busy),
    .res_valid (res_valid)
  );

  logic [SW-1:0]     acc_q, acc_d, sum_q;
  logic [3:0]        avg_i_q;
  logic [FRAC_W-1:0] avg_f_q;

  // The final sample is folded in on the same edge the result is captured.
  assign acc_d = acc_q + SW'(din);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      sum_q   <= '0;
      avg_i_q <= '0;
      avg_f_q <= '0;
    end else begin
      if (acc_clr)     acc_q <= '0;
      else if (acc_en) acc_q <= acc_d;
      if (done_load) begin
        sum_q   <= acc_d;
        avg_i_q <= acc_d[SW-1:LOG2_WIN];
        avg_f_q <= avg_frac(20'(acc_d), LOG2_WIN);
      end
    end
  end

  assign sum   = sum_q;
  assign avg_i = avg_i_q;
  assign avg_f = avg_f_q;

`ifdef STREAM_AVG_MINMAX_EN
  logic [DIN_W-1:0] mn_q, mx_q, mn_d, mx_d, din_min_q, din_max_q;

  assign mn_d = (din < mn_q) ? din : mn_q;
  assign mx_d = (din > mx_q) ? din : mx_q;

  // Trackers only move in ACCUM, so seeding them at start is equivalent to ACCUM entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mn_q      <= '0;
      mx_q      <= '0;
      din_min_q <= '0;
      din_max_q <= '0;
    end else begin
      if (acc_clr) begin
        mn_q <= '1;
        mx_q <= '0;
      end else if (acc_en) begin
        mn_q <= mn_d;
        mx_q <= mx_d;
      end
      if (done_load) begin
        din_min_q <= mn_d;
        din_max_q <= mx_d;
      end
    end
  end

  assign din_min = din_min_q;
  assign din_max = din_max_q;
`endif
endmodule

// File: tb/tb_stream_avg_decoder.sv
// Scoreboard bench: default instance plus a LOG2_WIN=1, SKIP=0 instance.
module tb_stream_avg_decoder;
  typedef struct {
    int unsigned sum;
    int unsigned ai;
    int unsigned af;
    int unsigned mn;
    int unsigned mx;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, res_ready, busy, res_valid;
  logic [3:0]  din, avg_i;
  logic [15:0] avg_f;
  logic [10:0] sum;
  logic start2, ready2, busy2, valid2;
  logic [3:0]  din2, avg_i2;
  logic [15:0] avg_f2;
  logic [4:0]  sum2;
`ifdef STREAM_AVG_MINMAX_EN
  logic [3:0] din_min, din_max, din_min2, din_max2;
`endif

  int ntests = 0, nfail = 0;
  int unsigned cyc = 0;
  exp_t q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_avg_decoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .avg_i(avg_i), .avg_f(avg_f), .sum(sum)
`ifdef STREAM_AVG_MINMAX_EN
    , .din_min(din_min), .din_max(din_max)
`endif
  );

  stream_avg_decoder #(.LOG2_WIN(1), .SKIP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .din(din2), .busy(busy2),
    .res_valid(valid2), .res_ready(ready2), .avg_i(avg_i2), .avg_f(avg_f2), .sum(sum2)
`ifdef STREAM_AVG_MINMAX_EN
    , .din_min(din_min2), .din_max(din_max2)
`endif
  );

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] pat(input int kind, input int k);
    case (kind)
      0: return 4'd8;
      1: return (k % 2 == 1) ? 4'd9 : 4'd8;
      2: return (k % 4 == 3) ? 4'd9 : 4'd8;
      3: return 4'd15;
      default: return 4'(k % 16);
    endcase
  endfunction

  // Monitor for the default instance: compares on rising res_valid, then holds
  // the result against the entry for stability until the handshake.
  initial begin
    exp_t cur;
    bit pv = 1'b0;
    cur = '{0, 0, 0, 0, 0, 0};
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        pv = 1'b0;
      end else if (pv && res_ready) begin
        chk("hs_valid_drop", res_valid, 0);
        chk("hs_no_restart", busy, 0);
        pv = res_valid;
      end else if (res_valid && !pv) begin
        if (q1.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          cur = q1.pop_front();
          chk("sum", sum, cur.sum);
          chk("avg_i", avg_i, cur.ai);
          chk("avg_f", avg_f, cur.af);
          chk("latency", cyc, cur.cyc);
          chk("busy_done", busy, 0);
`ifdef STREAM_AVG_MINMAX_EN
          chk("din_min", din_min, cur.mn);
          chk("din_max", din_max, cur.mx);
`endif
        end
        pv = 1'b1;
      end else begin
        if (res_valid) begin
          chk("hold_sum", sum, cur.sum);
          chk("hold_avg_f", avg_f, cur.af);
          chk("hold_avg_i", avg_i, cur.ai);
        end
        pv = res_valid;
      end
    end
  end

  initial begin
    exp_t cur;
    forever begin
      @(posedge clk); #1;
      if (rst_n && valid2) begin
        if (q2.size() == 0) chk("w1_unexpected_valid", 1, 0);
        else begin
          cur = q2.pop_front();
          chk("w1_sum", sum2, cur.sum);
          chk("w1_avg_i", avg_i2, cur.ai);
          chk("w1_avg_f", avg_f2, cur.af);
          chk("w1_latency", cyc, cur.cyc);
        end
      end
    end
  end

  // One measurement on the default instance; din is 15 outside the window so
  // an off-by-one in settle or window length shows up in the sum.
  task automatic meas(input int kind, input int unsigned es, input int unsigned ei,
                      input int unsigned ef, input int unsigned emn, input int unsigned emx,
                      input int hold, input int spulse, input bit do_rst);
    int n;
    @(negedge clk);
    start = 1'b1; din = 4'd15; res_ready = 1'b0;
    if (!do_rst) q1.push_back('{es, ei, ef, emn, emx, cyc + 1 + 4 + 128});
    repeat (4) begin @(negedge clk); start = 1'b0; din = 4'd15; end
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      din = pat(kind, k);
      start = (k == spulse);
      if (do_rst && k == 60) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_avg_i", avg_i, 0);
        chk("rst_avg_f", avg_f, 0);
        repeat (150) @(negedge clk);
        chk("rst_abandoned", busy, 0);
        return;
      end
    end
    @(negedge clk);
    din = 4'd15; start = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    if (n == 20) chk("valid_timeout", 0, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      din = 4'($urandom_range(0, 15));
      start = h[0];
    end
    @(negedge clk);
    res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_after_hs", busy, 0);
  endtask

  task automatic meas2(input logic [3:0] d0, input logic [3:0] d1, input int unsigned es,
                       input int unsigned ei, input int unsigned ef);
    @(negedge clk); start2 = 1'b1; din2 = 4'd0;
    q2.push_back('{es, ei, ef, 0, 0, cyc + 1 + 2});
    @(negedge clk); start2 = 1'b0; din2 = d0;
    @(negedge clk); din2 = d1;
    @(negedge clk); din2 = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; din = 4'd0; res_ready = 1'b0;
    start2 = 1'b0; din2 = 4'd0; ready2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", res_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_avg_i", avg_i, 0);
    chk("reset_avg_f", avg_f, 0);
    rst_n = 1'b1;
    @(negedge clk);

    meas(0, 1024, 8, 16'h0000, 8, 8, 10, -1, 1'b0);
    meas(1, 1088, 8, 16'h8000, 8, 9, 0, 50, 1'b0);
    meas(2, 1056, 8, 16'h4000, 8, 9, 2, -1, 1'b0);
    meas(3, 1920, 15, 16'h0000, 15, 15, 1, -1, 1'b0);
    meas(4, 960, 7, 16'h8000, 0, 15, 3, 100, 1'b0);
    meas(0, 0, 0, 0, 0, 0, 0, -1, 1'b1);
    meas(1, 1088, 8, 16'h8000, 8, 9, 0, -1, 1'b0);

    meas2(4'd3, 4'd4, 7, 3, 16'h8000);
    meas2(4'd15, 4'd14, 29, 14, 16'h8000);
    meas2(4'd15, 4'd15, 30, 15, 16'h0000);
    repeat (4) @(negedge clk);

    chk("queue1_drained", q1.size(), 0);
    chk("queue2_drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
